// File: rtl/cnn_frame_sequencer_if.sv
// Handshake bundle between the frame sequencer, its requester,
// the pixel BRAM and the CNN pipeline.
interface cnn_frame_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] img_base;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic              pipe_rst_n;
    logic              pipe_valid;
    logic [3:0]        pipe_decision;
    logic              busy;
    logic              done;
    logic [3:0]        decision;
    logic              err_timeout;
    logic [7:0]        frame_count;

    modport master (
        output start, img_base,
        output pipe_valid, pipe_decision,
        input  bram_addr, bram_en, pipe_rst_n,
        input  busy, done, decision,
        input  err_timeout, frame_count
    );

    modport slave (
        input  start, img_base,
        input  pipe_valid, pipe_decision,
        output bram_addr, bram_en, pipe_rst_n,
        output busy, done, decision,
        output err_timeout, frame_count
    );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Per-frame controller: resets the CNN pipeline, streams one image
// from pixel BRAM, captures the decision, with a drain watchdog.
module cnn_frame_sequencer #(
    parameter int PIX_COUNT    = 784,
    parameter int ADDR_W       = 16,
    parameter int PIPE_RST_CYC = 4,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cnn_frame_sequencer_if.slave  bus
);

    localparam int OFF_W = $clog2(PIX_COUNT);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    localparam logic [OFF_W-1:0] OFF_LAST =
        OFF_W'(PIX_COUNT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0] PRST_LAST =
        4'(PIPE_RST_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRST,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [OFF_W-1:0]  off_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [3:0]        prst_q;
    logic              cap_q;
    logic [3:0]        dec_q;
    logic              err_q;
    logic [7:0]        fcnt_q;

    logic              busy;
    logic              done;
    logic              pipe_rst_n;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic              accept;
    logic              cap_fire;
    logic              tmo_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy       = 1'b1;
        done       = 1'b0;
        pipe_rst_n = 1'b1;
        bram_en    = 1'b0;
        bram_addr  = addr_q;
        accept     = 1'b0;
        cap_fire   = 1'b0;
        tmo_fire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy       = 1'b0;
                pipe_rst_n = 1'b0;
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = PRST;
                end
            end
            PRST: begin
                pipe_rst_n = 1'b0;
                // pixel 0 is fetched here so it lands as reset lifts
                if (prst_q == PRST_LAST) begin
                    bram_en   = 1'b1;
                    bram_addr = base_q;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                bram_en   = 1'b1;
                bram_addr = base_q + ADDR_W'(off_q);
                cap_fire  = bus.pipe_valid && !cap_q;
                if (off_q == OFF_LAST) begin
                    if (cap_q || cap_fire) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                cap_fire = bus.pipe_valid && !cap_q;
                if (cap_fire) begin
                    state_d = DONE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_fire = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q <= '0;
            addr_q <= '0;
            off_q  <= '0;
            tmo_q  <= '0;
            prst_q <= '0;
            cap_q  <= 1'b0;
            dec_q  <= '0;
            err_q  <= 1'b0;
            fcnt_q <= '0;
        end else begin
            if (accept) begin
                base_q <= bus.img_base;
                err_q  <= 1'b0;
                cap_q  <= 1'b0;
            end
            if (state_q == PRST) begin
                prst_q <= prst_q + 4'd1;
            end else begin
                prst_q <= '0;
            end
            if (state_q == STREAM) begin
                off_q <= off_q + OFF_W'(1);
            end else begin
                off_q <= OFF_W'(1);
            end
            if (state_q == DRAIN) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end else begin
                tmo_q <= '0;
            end
            if (bram_en) begin
                addr_q <= bram_addr;
            end
            if (cap_fire) begin
                dec_q <= bus.pipe_decision;
                cap_q <= 1'b1;
            end
            if (tmo_fire) begin
                dec_q <= 4'hF;
                err_q <= 1'b1;
            end
            if (done) begin
                fcnt_q <= fcnt_q + 8'd1;
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.pipe_rst_n  = pipe_rst_n;
    assign bus.bram_en     = bram_en;
    assign bus.bram_addr   = bram_addr;
    assign bus.decision    = dec_q;
    assign bus.err_timeout = err_q;
    assign bus.frame_count = fcnt_q;

endmodule
